// File: rtl/bp_cce_mem_cmd_arbiter.sv
// Two-requester BedRock stream mem_cmd arbiter.
// Grants whole messages (header + data beats) with round-robin fairness.
module bp_cce_mem_cmd_arbiter #(
  parameter int header_width_p = 64,
  parameter int data_width_p   = 64
) (
  input  logic                      clk_i,
  input  logic                      reset_i,

  input  logic [header_width_p-1:0] req0_header_i,
  input  logic                      req0_header_v_i,
  output logic                      req0_header_ready_and_o,
  input  logic                      req0_has_data_i,
  input  logic [data_width_p-1:0]   req0_data_i,
  input  logic                      req0_data_v_i,
  output logic                      req0_data_ready_and_o,
  input  logic                      req0_last_i,

  input  logic [header_width_p-1:0] req1_header_i,
  input  logic                      req1_header_v_i,
  output logic                      req1_header_ready_and_o,
  input  logic                      req1_has_data_i,
  input  logic [data_width_p-1:0]   req1_data_i,
  input  logic                      req1_data_v_i,
  output logic                      req1_data_ready_and_o,
  input  logic                      req1_last_i,

  output logic [header_width_p-1:0] mem_cmd_header_o,
  output logic                      mem_cmd_header_v_o,
  input  logic                      mem_cmd_header_ready_and_i,
  output logic                      mem_cmd_has_data_o,
  output logic [data_width_p-1:0]   mem_cmd_data_o,
  output logic                      mem_cmd_data_v_o,
  input  logic                      mem_cmd_data_ready_and_i,
  output logic                      mem_cmd_last_o
);

  typedef enum logic [1:0] {
    e_ready,
    e_header,
    e_data
  } state_e;

  state_e state_q, state_d;
  logic   ptr_q, ptr_d;
  logic   grant_q, grant_d;
  logic   has_data_q, has_data_d;

  logic                      any_v;
  logic                      winner;
  logic                      sel;
  logic                      sel_hv;
  logic [header_width_p-1:0] sel_hdr;
  logic                      sel_hd;
  logic                      sel_dv;
  logic [data_width_p-1:0]   sel_data;
  logic                      sel_last;
  logic                      in_hdr;
  logic                      in_dat;
  logic                      hdr_rdy;
  logic                      dat_rdy;
  logic                      hs_h;
  logic                      hs_d;

  // Grant selection, output muxing and handshake gating
  always_comb begin
    any_v  = req0_header_v_i | req1_header_v_i;
    winner = (req0_header_v_i & req1_header_v_i)
           ? ptr_q : req1_header_v_i;
    sel    = (state_q == e_ready) ? winner : grant_q;

    sel_hv   = sel ? req1_header_v_i : req0_header_v_i;
    sel_hdr  = sel ? req1_header_i   : req0_header_i;
    sel_hd   = sel ? req1_has_data_i : req0_has_data_i;
    sel_dv   = sel ? req1_data_v_i   : req0_data_v_i;
    sel_data = sel ? req1_data_i     : req0_data_i;
    sel_last = sel ? req1_last_i     : req0_last_i;

    // reset_i gates everything so nothing handshakes while in reset
    in_hdr = reset_i & (state_q != e_data);
    in_dat = reset_i & (state_q == e_data);

    mem_cmd_header_o   = sel_hdr;
    mem_cmd_header_v_o = in_hdr & sel_hv;
    mem_cmd_has_data_o = mem_cmd_header_v_o
                       & ((state_q == e_header) ? has_data_q : sel_hd);
    mem_cmd_data_o     = sel_data;
    mem_cmd_data_v_o   = in_dat & sel_dv;
    mem_cmd_last_o     = mem_cmd_data_v_o & sel_last;

    hdr_rdy = in_hdr & mem_cmd_header_ready_and_i;
    dat_rdy = in_dat & mem_cmd_data_ready_and_i;

    req0_header_ready_and_o = hdr_rdy & ~sel;
    req1_header_ready_and_o = hdr_rdy &  sel;
    req0_data_ready_and_o   = dat_rdy & ~sel;
    req1_data_ready_and_o   = dat_rdy &  sel;

    hs_h = mem_cmd_header_v_o & mem_cmd_header_ready_and_i;
    hs_d = mem_cmd_data_v_o & mem_cmd_data_ready_and_i;
  end

  // Message lock FSM next-state and pointer update
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    has_data_d = has_data_q;
    unique case (state_q)
      e_ready: begin
        if (any_v) begin
          grant_d    = winner;
          has_data_d = sel_hd;
          if (mem_cmd_header_ready_and_i) begin
            if (sel_hd) state_d = e_data;
            else        ptr_d   = ~winner;
          end else begin
            state_d = e_header;
          end
        end
      end
      e_header: begin
        if (hs_h) begin
          if (has_data_q) begin
            state_d = e_data;
          end else begin
            state_d = e_ready;
            ptr_d   = ~grant_q;
          end
        end
      end
      e_data: begin
        if (hs_d & sel_last) begin
          state_d = e_ready;
          ptr_d   = ~grant_q;
        end
      end
      default: state_d = e_ready;
    endcase
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= e_ready;
      ptr_q      <= 1'b0;
      grant_q    <= 1'b0;
      has_data_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      has_data_q <= has_data_d;
    end
  end

endmodule

// File: tb/tb_bp_cce_mem_cmd_arbiter.sv
// Directed self-checking bench for bp_cce_mem_cmd_arbiter.
// Steps drive just after posedge and check settled outputs 1ns later.
module tb_bp_cce_mem_cmd_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [63:0] h0, h1, d0, d1;
  logic        hv0, hv1, hd0, hd1, dv0, dv1, l0, l1;
  logic        hr0, hr1, dr0, dr1;
  logic [63:0] mh, md;
  logic        mhv, mhd, mdv, ml;
  logic        mh_rdy, md_rdy;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  bp_cce_mem_cmd_arbiter #(
    .header_width_p(64),
    .data_width_p  (64)
  ) dut (
    .clk_i                     (clk_i),
    .reset_i                   (reset_i),
    .req0_header_i             (h0),
    .req0_header_v_i           (hv0),
    .req0_header_ready_and_o   (hr0),
    .req0_has_data_i           (hd0),
    .req0_data_i               (d0),
    .req0_data_v_i             (dv0),
    .req0_data_ready_and_o     (dr0),
    .req0_last_i               (l0),
    .req1_header_i             (h1),
    .req1_header_v_i           (hv1),
    .req1_header_ready_and_o   (hr1),
    .req1_has_data_i           (hd1),
    .req1_data_i               (d1),
    .req1_data_v_i             (dv1),
    .req1_data_ready_and_o     (dr1),
    .req1_last_i               (l1),
    .mem_cmd_header_o          (mh),
    .mem_cmd_header_v_o        (mhv),
    .mem_cmd_header_ready_and_i(mh_rdy),
    .mem_cmd_has_data_o        (mhd),
    .mem_cmd_data_o            (md),
    .mem_cmd_data_v_o          (mdv),
    .mem_cmd_data_ready_and_i  (md_rdy),
    .mem_cmd_last_o            (ml)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ex(input string tag,
                    input logic hv, input logic [63:0] h,
                    input logic hd,
                    input logic dv, input logic [63:0] d,
                    input logic l,
                    input logic rh0, input logic rh1,
                    input logic rd0, input logic rd1);
    #1;
    chk({tag, ".hv"}, {63'd0, mhv}, {63'd0, hv});
    if (hv) chk({tag, ".hdr"}, mh, h);
    chk({tag, ".hd"}, {63'd0, mhd}, {63'd0, hd});
    chk({tag, ".dv"}, {63'd0, mdv}, {63'd0, dv});
    if (dv) chk({tag, ".data"}, md, d);
    chk({tag, ".last"}, {63'd0, ml}, {63'd0, l});
    chk({tag, ".hr0"}, {63'd0, hr0}, {63'd0, rh0});
    chk({tag, ".hr1"}, {63'd0, hr1}, {63'd0, rh1});
    chk({tag, ".dr0"}, {63'd0, dr0}, {63'd0, rd0});
    chk({tag, ".dr1"}, {63'd0, dr1}, {63'd0, rd1});
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    reset_i = 1'b0;
    h0 = 64'hA0; h1 = 64'hB1; d0 = 64'h0; d1 = 64'h0;
    hv0 = 1; hv1 = 1; hd0 = 0; hd1 = 0;
    dv0 = 1; dv1 = 1; l0 = 1; l1 = 1;
    mh_rdy = 1; md_rdy = 1;
    // reset: everything quiet regardless of inputs
    ex("rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(); cyc();
    reset_i = 1'b1;
    dv0 = 0; dv1 = 0; l0 = 0; l1 = 0;

    // tie after reset: req0 then req1
    ex("tie_c1", 1, 64'hA0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc();
    ex("tie_c2", 1, 64'hB1, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc();
    ex("tie_c3", 1, 64'hA0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc();
    hv0 = 0; hv1 = 0;
    // ptr = 1

    // req1 4-beat message, req0 arrives mid-stream
    h1 = 64'hC1; hd1 = 1; hv1 = 1;
    ex("m4_hdr", 1, 64'hC1, 1, 0, 0, 0, 0, 1, 0, 0);
    cyc();
    hv1 = 0; hd1 = 0;
    dv0 = 1; d0 = 64'hBAD0;
    dv1 = 1; d1 = 64'hD0; l1 = 0;
    ex("m4_b0", 0, 0, 0, 1, 64'hD0, 0, 0, 0, 0, 1);
    cyc();
    d1 = 64'hD1;
    ex("m4_b1", 0, 0, 0, 1, 64'hD1, 0, 0, 0, 0, 1);
    cyc();
    d1 = 64'hD2;
    hv0 = 1; h0 = 64'hE0; hd0 = 0;
    ex("m4_b2", 0, 0, 0, 1, 64'hD2, 0, 0, 0, 0, 1);
    cyc();
    d1 = 64'hD3; l1 = 1;
    ex("m4_b3", 0, 0, 0, 1, 64'hD3, 1, 0, 0, 0, 1);
    cyc();
    dv1 = 0; l1 = 0; dv0 = 0;
    ex("m4_next", 1, 64'hE0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc();
    hv0 = 0;
    // ptr = 1

    // header stall with locked grant; data offered early
    h0 = 64'hF0; hv0 = 1; hd0 = 0; mh_rdy = 0;
    dv0 = 1; d0 = 64'hBAD1;
    ex("st_c1", 1, 64'hF0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    h1 = 64'h61; hv1 = 1;
    ex("st_c2", 1, 64'hF0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    ex("st_c3", 1, 64'hF0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    mh_rdy = 1;
    ex("st_c4", 1, 64'hF0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc();
    hv0 = 0; dv0 = 0;
    ex("st_r1", 1, 64'h61, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc();
    hv1 = 0;
    // ptr = 0

    // single beat message with data ready toggling
    h0 = 64'h40; hv0 = 1; hd0 = 1;
    ex("sb_hdr", 1, 64'h40, 1, 0, 0, 0, 1, 0, 0, 0);
    cyc();
    hv0 = 0; hd0 = 0;
    dv0 = 1; d0 = 64'h50; l0 = 1; md_rdy = 0;
    ex("sb_stall", 0, 0, 0, 1, 64'h50, 1, 0, 0, 0, 0);
    cyc();
    md_rdy = 1;
    ex("sb_beat", 0, 0, 0, 1, 64'h50, 1, 0, 0, 1, 0);
    cyc();
    ex("sb_done", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    dv0 = 0; l0 = 0;
    h0 = 64'hA0; h1 = 64'hB1; hv0 = 1; hv1 = 1;
    ex("sb_ptr1", 1, 64'hB1, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc();
    hv0 = 0; hv1 = 0;
    // ptr = 0

    // data offered during e_ready/e_header must wait
    h0 = 64'h60; hv0 = 1; hd0 = 1; mh_rdy = 0;
    dv0 = 1; d0 = 64'h70; l0 = 1;
    ex("ed_rdy", 1, 64'h60, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    ex("ed_hdr", 1, 64'h60, 1, 0, 0, 0, 0, 0, 0, 0);
    mh_rdy = 1;
    ex("ed_hs", 1, 64'h60, 1, 0, 0, 0, 1, 0, 0, 0);
    cyc();
    hv0 = 0; hd0 = 0;
    ex("ed_beat", 0, 0, 0, 1, 64'h70, 1, 0, 0, 1, 0);
    cyc();
    ex("ed_once", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    dv0 = 0; l0 = 0;
    // ptr = 1

    // reset in the middle of a 4-beat message
    h1 = 64'h81; hv1 = 1; hd1 = 1;
    ex("rm_hdr", 1, 64'h81, 1, 0, 0, 0, 0, 1, 0, 0);
    cyc();
    hv1 = 0; hd1 = 0;
    dv1 = 1; d1 = 64'h90; l1 = 0;
    ex("rm_b0", 0, 0, 0, 1, 64'h90, 0, 0, 0, 0, 1);
    cyc();
    d1 = 64'h91;
    ex("rm_b1", 0, 0, 0, 1, 64'h91, 0, 0, 0, 0, 1);
    cyc();
    d1 = 64'h92;
    h0 = 64'hA0; h1 = 64'hB1; hv0 = 1; hv1 = 1;
    reset_i = 1'b0;
    ex("rm_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    reset_i = 1'b1;
    ex("rm_after", 1, 64'hA0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
